control_micro_seq: RTL
======================

Name: control_micro_seq

Overview:
- Parametrised successor to the micro control unit: program sequencer, flag latch and jump logic in one block.
- Adds a hardware call/return stack, a stall input, a halt instruction and a sticky fault state.
- Instruction memory is external and combinational: i_instruccion is the word at o_direccion_instruccion in the current cycle.
- Datapath control fields are issued registered, one cycle after decode.

Parameters:
INSTR_W, 16, instruction width; must be >= ADDR_W+8
ADDR_W, 8, program address width
DATA_W, 8, width of register value tested by JZ
FLAG_W, 3, number of ALU flags (1..8)
STACK_DEPTH, 4, call stack entries (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
i_instruccion  in  INSTR_W  current instruction
i_rx  in  DATA_W  datapath register value for JZ
i_ban  in  FLAG_W  ALU flags from datapath
i_stall  in  1  freeze all state this cycle
o_direccion_instruccion  out  ADDR_W  program counter
o_ctrl  out  INSTR_W-4  registered datapath control field
o_ctrl_valid  out  1  o_ctrl carries an EXEC this cycle
o_flags  out  FLAG_W  latched flag register
o_sp  out  clog2(STACK_DEPTH+1)  stack occupancy
o_halted  out  1  HALT state
o_fault  out  1  FAULT state

Behaviour:
- Reset (rst=0, asynchronous): PC=0, flags=0, sp=0, o_ctrl=0, o_ctrl_valid=0, state=RUN, o_halted=0, o_fault=0. Stack contents are don't-care.
- Fields:
  - opc = instr[INSTR_W-1 -: 4].
  - cond = instr[INSTR_W-5 -: 4]; bit3 = polarity, bits2:0 = flag index.
  - tgt = instr[ADDR_W-1:0].
  - ctrl = instr[INSTR_W-5:0].
- States:
  - RUN: executes one instruction per un-stalled cycle.
  - HALT: PC frozen, o_halted=1; left only by reset.
  - FAULT: PC frozen, o_fault=1; left only by reset.
- Opcodes in RUN; all non-jump opcodes set PC<=PC+1:
  - 0x0 NOP.
  - 0x1 EXEC: next cycle o_ctrl=ctrl and o_ctrl_valid=1. Every other cycle o_ctrl_valid=0 and o_ctrl holds its last value.
  - 0x5 LDFLAG: flags<=i_ban.
  - 0x8 JMP: PC<=tgt.
  - 0x9 JCC: taken when index<FLAG_W and flags[index]==polarity; taken -> PC<=tgt, else PC+1. Index>=FLAG_W is never taken. Uses the latched flags, not i_ban.
  - 0xA JZ: taken when i_rx==0.
  - 0xB CALL: push PC+1, sp+1, PC<=tgt. If sp==STACK_DEPTH: no push, PC held, go to FAULT.
  - 0xC RET: pop, PC<=popped value, sp-1. If sp==0: PC held, go to FAULT.
  - 0xF HALT: PC held, go to HALT.
  - All other opcodes behave as NOP.
- PC+1 wraps from 2^ADDR_W-1 to 0, both in sequencing and in the value pushed by CALL.
- i_stall=1 takes priority over everything except reset:
  - PC, flags, stack, sp and state all hold.
  - o_ctrl_valid=0 next cycle.
  - The instruction is re-presented and executes on the first un-stalled cycle.
- HALT and FAULT ignore instructions and stall; o_ctrl_valid=0.
- Flag latch and branch decisions are single-cycle: a JCC immediately after LDFLAG sees the new flags.
- Jump penalty is zero: the target address appears on o_direccion_instruccion the cycle after the jump.
- Reset asserted mid-CALL/RET or mid-stall aborts the operation with no partial stack update visible.

Test Plan:
- Release reset, program NOP x3 then HALT at 3 -> PC 0,1,2,3 and holds at 3; o_halted=1 from the cycle after HALT; i_stall toggling has no effect.
- LDFLAG with i_ban=3'b010, then JCC cond=4'b1001 tgt=0x40 -> PC=0x40. Repeat with i_ban=3'b000 -> PC=addr+1. cond index 7 with FLAG_W=3 -> never taken.
- CALL 0x20 at PC=0x10, RET at 0x20 -> PC 0x20 then 0x11, o_sp 1 then 0. Nest 4 CALLs then a 5th with STACK_DEPTH=4 -> o_fault=1, PC frozen at the 5th CALL, o_sp=4.
- RET with empty stack -> o_fault=1; only an rst low pulse clears it, giving PC=0 and o_sp=0.
- EXEC ctrl=0x0AB followed by NOP -> o_ctrl=0x0AB with o_ctrl_valid=1 for exactly one cycle. Same EXEC with i_stall=1 for 2 cycles -> PC held, valid low, then a single valid pulse after the stall.
- PC at 0xFF executing NOP -> PC=0x00. CALL at 0xFF -> pushed 0x00, and RET returns to 0x00.

Source files
------------

// File: rtl/control_micro_seq.sv
// Program sequencer with flag latch, conditional jumps, hardware call/return stack,
// stall freeze, and terminal HALT/FAULT states. Instruction memory is external and combinational.
module control_micro_seq #(
    parameter int INSTR_W     = 16,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int FLAG_W      = 3,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [INSTR_W-1:0]                 i_instruccion,
    input  logic [DATA_W-1:0]                  i_rx,
    input  logic [FLAG_W-1:0]                  i_ban,
    input  logic                               i_stall,
    output logic [ADDR_W-1:0]                  o_direccion_instruccion,
    output logic [INSTR_W-5:0]                 o_ctrl,
    output logic                               o_ctrl_valid,
    output logic [FLAG_W-1:0]                  o_flags,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   o_sp,
    output logic                               o_halted,
    output logic                               o_fault
);

    localparam int SP_W          = $clog2(STACK_DEPTH + 1);
    localparam int STACK_ENTRIES = 1 << SP_W;

    localparam logic [3:0] OP_EXEC   = 4'h1;
    localparam logic [3:0] OP_LDFLAG = 4'h5;
    localparam logic [3:0] OP_JMP    = 4'h8;
    localparam logic [3:0] OP_JCC    = 4'h9;
    localparam logic [3:0] OP_JZ     = 4'hA;
    localparam logic [3:0] OP_CALL   = 4'hB;
    localparam logic [3:0] OP_RET    = 4'hC;
    localparam logic [3:0] OP_HALT   = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_FAULT
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   pc, pc_next, pc_inc;
    logic [FLAG_W-1:0]   flags, flags_next;
    logic [SP_W-1:0]     sp, sp_next, sp_dec;
    logic [INSTR_W-5:0]  ctrl_q, ctrl_next;
    logic                ctrl_valid, valid_next;
    logic                push;
    logic [ADDR_W-1:0]   stack_mem [STACK_ENTRIES];

    logic [3:0]          opc;
    logic [3:0]          cond;
    logic [ADDR_W-1:0]   tgt;
    logic [INSTR_W-5:0]  ctrl_field;
    logic [7:0]          flags_ext;
    logic                jcc_taken;
    logic                stack_full;
    logic                stack_empty;

    assign opc        = i_instruccion[INSTR_W-1 -: 4];
    assign cond       = i_instruccion[INSTR_W-5 -: 4];
    assign tgt        = i_instruccion[ADDR_W-1:0];
    assign ctrl_field = i_instruccion[INSTR_W-5:0];

    assign pc_inc      = pc + 1'b1;
    assign sp_dec      = sp - 1'b1;
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);

    // Zero-extended so any 3-bit index is a legal select; the range test rejects indices past FLAG_W.
    assign flags_ext = 8'(flags);
    assign jcc_taken = (32'(cond[2:0]) < FLAG_W) && (flags_ext[cond[2:0]] == cond[3]);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        flags_next = flags;
        sp_next    = sp;
        ctrl_next  = ctrl_q;
        valid_next = 1'b0;
        push       = 1'b0;
        if (state == ST_RUN && !i_stall) begin
            pc_next = pc_inc;
            case (opc)
                OP_EXEC: begin
                    ctrl_next  = ctrl_field;
                    valid_next = 1'b1;
                end
                OP_LDFLAG: flags_next = i_ban;
                OP_JMP:    pc_next = tgt;
                OP_JCC:    if (jcc_taken) pc_next = tgt;
                OP_JZ:     if (i_rx == '0) pc_next = tgt;
                OP_CALL: begin
                    if (stack_full) begin
                        pc_next    = pc;
                        state_next = ST_FAULT;
                    end else begin
                        push    = 1'b1;
                        sp_next = sp + 1'b1;
                        pc_next = tgt;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        pc_next    = pc;
                        state_next = ST_FAULT;
                    end else begin
                        pc_next = stack_mem[sp_dec];
                        sp_next = sp_dec;
                    end
                end
                OP_HALT: begin
                    pc_next    = pc;
                    state_next = ST_HALT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            pc         <= '0;
            flags      <= '0;
            sp         <= '0;
            ctrl_q     <= '0;
            ctrl_valid <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            flags      <= flags_next;
            sp         <= sp_next;
            ctrl_q     <= ctrl_next;
            ctrl_valid <= valid_next;
        end
    end

    // Stack contents need no reset: sp returns to zero, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) stack_mem[sp] <= pc_inc;
    end

    assign o_direccion_instruccion = pc;
    assign o_ctrl                  = ctrl_q;
    assign o_ctrl_valid            = ctrl_valid;
    assign o_flags                 = flags;
    assign o_sp                    = sp;
    assign o_halted                = (state == ST_HALT);
    assign o_fault                 = (state == ST_FAULT);

endmodule
